// File: rtl/team_04_keypad_scanner.sv
// 4x4 matrix keypad scanner: column-at-a-time drive, 2-flop row synchroniser,
// full-sweep debounce with one report per press, and a valid/ready key output.
module team_04_keypad_scanner #(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned DEBOUNCE_SCANS = 3
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       en,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       key_valid,
    output logic [3:0] key_code,
    input  logic       key_ready,
    output logic       overrun
);

    localparam int unsigned SW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_EVAL
    } state_t;

    state_t          state;
    logic [3:0]      row_meta;
    logic [3:0]      row_sync;
    logic [1:0]      col;
    logic [SW-1:0]   settle_cnt;
    logic [15:0]     snapshot;
    logic [15:0]     prev_snapshot;
    logic [CW-1:0]   stable_cnt;
    logic            armed;

    logic [CW-1:0]   next_cnt;
    logic            settled;
    logic            single;
    logic [3:0]      hit_idx;
    logic            accept;

    // Snapshot bit index is col*4+row; the reported code swaps the halves.
    always_comb begin
        if (snapshot != prev_snapshot) begin
            next_cnt = CW'(1);
        end else if (stable_cnt == CW'(DEBOUNCE_SCANS)) begin
            next_cnt = stable_cnt;
        end else begin
            next_cnt = stable_cnt + CW'(1);
        end
        settled = (next_cnt == CW'(DEBOUNCE_SCANS));
        single  = $onehot(snapshot);
        hit_idx = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (snapshot[i]) begin
                hit_idx = i[3:0];
            end
        end
        accept = key_valid && key_ready;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state         <= ST_IDLE;
            row_meta      <= '0;
            row_sync      <= '0;
            col           <= '0;
            settle_cnt    <= '0;
            snapshot      <= '0;
            prev_snapshot <= '0;
            stable_cnt    <= '0;
            armed         <= 1'b1;
            col_out       <= '0;
            key_valid     <= 1'b0;
            key_code      <= '0;
            overrun       <= 1'b0;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
            overrun  <= 1'b0;
            if (accept) begin
                key_valid <= 1'b0;
            end

            if (!en) begin
                state         <= ST_IDLE;
                col_out       <= '0;
                col           <= '0;
                settle_cnt    <= '0;
                snapshot      <= '0;
                prev_snapshot <= '0;
                stable_cnt    <= '0;
                armed         <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state      <= ST_DRIVE;
                        col        <= '0;
                        settle_cnt <= '0;
                        col_out    <= 4'b0001;
                    end
                    ST_DRIVE: begin
                        if (settle_cnt == SW'(SETTLE_CYCLES - 2)) begin
                            state <= ST_SAMPLE;
                        end else begin
                            settle_cnt <= settle_cnt + SW'(1);
                        end
                    end
                    ST_SAMPLE: begin
                        snapshot[{col, 2'b00} +: 4] <= row_sync;
                        if (col == 2'd3) begin
                            state   <= ST_EVAL;
                            col_out <= '0;
                        end else begin
                            state      <= ST_DRIVE;
                            col        <= col + 2'd1;
                            settle_cnt <= '0;
                            col_out    <= col_out << 1;
                        end
                    end
                    ST_EVAL: begin
                        stable_cnt    <= next_cnt;
                        prev_snapshot <= snapshot;
                        state         <= ST_DRIVE;
                        col           <= '0;
                        settle_cnt    <= '0;
                        col_out       <= 4'b0001;
                        if (settled) begin
                            if (single && armed) begin
                                // A dropped key still disarms, so a held key overruns only once.
                                armed <= 1'b0;
                                if (!key_valid || key_ready) begin
                                    key_code  <= {hit_idx[1:0], hit_idx[3:2]};
                                    key_valid <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
                                end
                            end else if (snapshot == '0) begin
                                armed <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        col_out <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_team_04_keypad_scanner.sv
// Bench for team_04_keypad_scanner: emulated keypad, sweep-level reference model,
// and a scoreboard of expected key codes popped on each valid/ready transfer.
module tb_team_04_keypad_scanner;

    localparam int unsigned S     = 4;
    localparam int unsigned D     = 3;
    localparam int unsigned SWEEP = 4 * S + 1;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        en = 1'b0;
    logic        key_ready = 1'b0;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        overrun;
    logic [15:0] pressed = '0;   // bit (row*4+col) set = key held down

    int tests = 0;
    int fails = 0;

    bit          in_sweep;
    int unsigned phase;
    logic [15:0] last_mask;
    int unsigned run;
    bit          armed;
    bit          exp_valid;
    bit          exp_ovr;
    logic [3:0]  exp_col;
    logic [3:0]  code_q[$];
    bit          rand_ready = 1'b0;

    team_04_keypad_scanner #(
        .SETTLE_CYCLES (S),
        .DEBOUNCE_SCANS(D)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .en       (en),
        .row_in   (row_in),
        .col_out  (col_out),
        .key_valid(key_valid),
        .key_code (key_code),
        .key_ready(key_ready),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    // Ideal keypad: a row reads high when a held key sits on a driven column.
    always_comb begin
        row_in = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r * 4 + c] && col_out[c]) begin
                    row_in[r] = 1'b1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        in_sweep  = 1'b0;
        phase     = 0;
        last_mask = '0;
        run       = 0;
        armed     = 1'b1;
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
        exp_col   = '0;
        code_q.delete();
    endfunction

    // Advances the reference by one clock edge using the inputs held across it.
    function automatic void model_edge();
        bit         acc;
        bit         rep;
        logic [3:0] code;
        exp_ovr = 1'b0;
        if (!nrst) begin
            model_reset();
            return;
        end
        acc  = exp_valid && key_ready;
        rep  = 1'b0;
        code = '0;
        if (!en) begin
            in_sweep  = 1'b0;
            phase     = 0;
            last_mask = '0;
            run       = 0;
            armed     = 1'b1;
        end else if (!in_sweep) begin
            in_sweep = 1'b1;
            phase    = 0;
        end else if (phase == 4 * S) begin
            phase = 0;
            if (pressed == last_mask) begin
                if (run < D) run = run + 1;
            end else begin
                run = 1;
            end
            last_mask = pressed;
            if (run >= D) begin
                if ($countones(pressed) == 1 && armed) begin
                    rep   = 1'b1;
                    armed = 1'b0;
                    for (int k = 0; k < 16; k++) begin
                        if (pressed[k]) code = 4'(k);
                    end
                end else if (pressed == '0) begin
                    armed = 1'b1;
                end
            end
        end else begin
            phase = phase + 1;
        end
        if (rep) begin
            if (!exp_valid || acc) begin
                code_q.push_back(code);
                exp_valid = 1'b1;
            end else begin
                exp_ovr = 1'b1;
            end
        end else if (acc) begin
            exp_valid = 1'b0;
        end
        exp_col = (in_sweep && phase < 4 * S) ? (4'b0001 << (phase / S)) : 4'b0000;
    endfunction

    initial begin
        logic [3:0] want;
        forever begin
            @(negedge clk);
            if (nrst) begin
                check("col_out", col_out, exp_col);
                check("key_valid", {3'b000, key_valid}, {3'b000, exp_valid});
                check("overrun", {3'b000, overrun}, {3'b000, exp_ovr});
                if (key_valid && key_ready) begin
                    if (code_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL key_code: transfer of %h with no expected key at %0t", key_code, $time);
                    end else begin
                        want = code_q.pop_front();
                        check("key_code", key_code, want);
                    end
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        model_edge();
        if (rand_ready) key_ready = ($urandom_range(0, 2) == 0);
    endtask

    task automatic sweeps(input int unsigned n);
        repeat (n * SWEEP) cycle();
    endtask

    task automatic set_keys(input logic [15:0] m);
        int unsigned guard = 0;
        while (en && in_sweep && phase != 0 && guard < 2 * SWEEP) begin
            cycle();
            guard++;
        end
        pressed = m;
    endtask

    task automatic check_reset_outputs();
        check("rst col_out", col_out, 4'h0);
        check("rst key_valid", {3'b000, key_valid}, 4'h0);
        check("rst key_code", key_code, 4'h0);
        check("rst overrun", {3'b000, overrun}, 4'h0);
    endtask

    initial begin
        int unsigned kind;
        logic [15:0] m;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        nrst = 1'b1;
        cycle();
        en = 1'b1;
        sweeps(2);

        set_keys(16'h0001 << 9);
        sweeps(4);
        key_ready = 1'b1;
        cycle();
        cycle();
        key_ready = 1'b0;
        sweeps(3);

        set_keys('0);
        sweeps(3);
        set_keys(16'h0001 << 3);
        sweeps(4);
        key_ready = 1'b1;
        cycle();
        key_ready = 1'b0;
        set_keys('0);
        sweeps(3);
        set_keys(16'h0001 << 3);
        sweeps(2);
        set_keys('0);
        sweeps(3);

        set_keys(16'h0011);
        sweeps(4);
        set_keys('0);
        sweeps(3);

        key_ready = 1'b0;
        set_keys(16'h0001 << 5);
        sweeps(3);
        set_keys('0);
        sweeps(3);
        set_keys(16'h0001 << 10);
        sweeps(4);
        key_ready = 1'b1;
        cycle();
        key_ready = 1'b0;
        set_keys('0);
        sweeps(3);

        set_keys(16'h0001 << 6);
        sweeps(3);
        repeat (8) cycle();
        en = 1'b0;
        cycle();
        cycle();
        en = 1'b1;
        sweeps(4);
        key_ready = 1'b1;
        cycle();
        cycle();
        key_ready = 1'b0;

        repeat (5) cycle();
        nrst = 1'b0;
        model_reset();
        #1;
        check_reset_outputs();
        cycle();
        cycle();
        nrst = 1'b1;
        pressed = '0;
        cycle();

        rand_ready = 1'b1;
        repeat (40) begin
            kind = $urandom_range(0, 5);
            if (kind < 2) begin
                m = '0;
            end else if (kind < 5) begin
                m = 16'h0001 << $urandom_range(0, 15);
            end else begin
                m = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            end
            set_keys(m);
            sweeps($urandom_range(1, 4));
            if ($urandom_range(0, 9) == 0) begin
                repeat ($urandom_range(1, 16)) cycle();
                en = 1'b0;
                repeat ($urandom_range(1, 5)) cycle();
                en = 1'b1;
                cycle();
            end
        end

        rand_ready = 1'b0;
        key_ready  = 1'b1;
        set_keys('0);
        repeat (4) cycle();
        tests++;
        if (code_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected keys never transferred, expected 0", code_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
